add_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 4-bit signed add unit.
- Accepts one request at a time and latches its operands.
- Drives the add unit's enable and operand inputs for exactly one cycle.
- Registers the sum and signed-overflow flag, then returns them with a one-cycle done pulse to the winning requester.
- Keeps a saturating overflow-event counter for status readout.

---
 rtl/add_arbiter_pkg.sv | 13 +
 rtl/add_arbiter_rr.sv | 22 ++
 rtl/add_arbiter.sv | 122 ++++++++++++
 tb/tb_add_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types for the add-unit arbiter: FSM state encoding and requester ids.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_arbiter_rr.sv
// Combinational two-way round-robin pick; a tie goes to the requester not served last.
module add_arb_rr
  import add_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = REQ0;
    if (req0 && req1) begin
      winner = ~last_served;
    end else if (req1) begin
      winner = REQ1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter and sequencer for a shared signed add unit: latch operands,
// drive the unit for one cycle, register the sum and return it with a done pulse.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic             add_en,
  output logic [WIDTH-1:0] add_rd1,
  output logic [WIDTH-1:0] add_rd2,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             winner_q, winner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic any_req;
  logic pick;

  add_arb_rr u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_q),
    .any_req     (any_req),
    .winner      (pick)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    winner_d = winner_q;
    last_d   = last_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          op_a_d   = (pick == REQ1) ? a1 : a0;
          op_b_d   = (pick == REQ1) ? b1 : b0;
          winner_d = pick;
          last_d   = pick;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = add_result;
        ovf_d    = add_overflow;
        state_d  = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over a same-cycle increment; the increment saturates at all-ones.
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (state_q == ST_EXEC && add_overflow && cnt_q != '1) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      winner_q <= REQ0;
      last_q   <= REQ1;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign add_en   = (state_q == ST_EXEC);
  assign add_rd1  = add_en ? op_a_q : '0;
  assign add_rd2  = add_en ? op_b_q : '0;
  assign gnt0     = add_en && (winner_q == REQ0);
  assign gnt1     = add_en && (winner_q == REQ1);
  assign done0    = (state_q == ST_RESP) && (winner_q == REQ0);
  assign done1    = (state_q == ST_RESP) && (winner_q == REQ1);
  assign busy     = (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a behavioural 4-bit signed add unit attached.
module tb_add_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] result;
  logic       overflow, busy, add_en;
  logic [3:0] add_rd1, add_rd2;
  logic [3:0] add_result;
  logic       add_overflow;
  logic       ovf_clr;
  logic [7:0] ovf_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  // Shared add unit: 4-bit wrap, signed overflow when operand signs agree and sum sign differs.
  always_comb begin
    add_result   = add_rd1 + add_rd2;
    add_overflow = (add_rd1[3] == add_rd2[3]) && (add_result[3] != add_rd1[3]);
  end

  add_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .overflow(overflow), .busy(busy),
    .add_en(add_en), .add_rd1(add_rd1), .add_rd2(add_rd2),
    .add_result(add_result), .add_overflow(add_overflow),
    .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"},  {gnt0, gnt1}, 0);
    chk({tag, ".done"}, {done0, done1}, 0);
    chk({tag, ".res"},  {overflow, result}, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".add"},  {add_en, add_rd1, add_rd2}, 0);
    chk({tag, ".cnt"},  ovf_cnt, 0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; ovf_clr = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    cyc();
    chk_all_zero("reset");
    cyc();
    rst_n = 1'b1;

    // 1: single request 3+4
    req0 = 1; a0 = 4'd3; b0 = 4'd4;
    cyc();
    chk("t1.exec.gnt", {gnt0, gnt1}, 2'b10);
    chk("t1.exec.add", {add_en, add_rd1, add_rd2}, {1'b1, 4'd3, 4'd4});
    chk("t1.exec.busy", busy, 1);
    req0 = 0;
    cyc();
    chk("t1.resp.done", {done0, done1}, 2'b10);
    chk("t1.resp.res", {overflow, result}, {1'b0, 4'd7});
    chk("t1.resp.add", {add_en, add_rd1, add_rd2}, 0);
    cyc();
    chk("t1.idle.done", {done0, done1, busy}, 0);
    chk("t1.idle.hold", result, 4'd7);

    // 2: simultaneous requests after reset, requester 0 first
    do_reset();
    req0 = 1; a0 = 4'd5; b0 = 4'd4;
    req1 = 1; a1 = 4'd1; b1 = 4'd1;
    cyc();
    chk("t2.exec0.gnt", {gnt0, gnt1}, 2'b10);
    chk("t2.exec0.add", {add_rd1, add_rd2}, {4'd5, 4'd4});
    cyc();
    chk("t2.resp0.done", {done0, done1}, 2'b10);
    chk("t2.resp0.res", {overflow, result}, {1'b1, 4'b1001});
    chk("t2.resp0.cnt", ovf_cnt, 1);
    req0 = 0;
    cyc();
    chk("t2.idle.done", {done0, done1}, 0);
    cyc();
    chk("t2.exec1.gnt", {gnt0, gnt1}, 2'b01);
    chk("t2.exec1.add", {add_rd1, add_rd2}, {4'd1, 4'd1});
    cyc();
    chk("t2.resp1.done", {done0, done1}, 2'b01);
    chk("t2.resp1.res", {overflow, result}, {1'b0, 4'd2});
    chk("t2.resp1.cnt", ovf_cnt, 1);
    req1 = 0;
    cyc();

    // 3: both held high for eight operations -> strict alternation starting with 0
    req0 = 1; a0 = 4'd1; b0 = 4'd1;
    req1 = 1; a1 = 4'd2; b1 = 4'd2;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("t3.%0d.gnt", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
      chk($sformatf("t3.%0d.done", i), {done0, done1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("t3.%0d.res", i), result, (i % 2 == 0) ? 4'd2 : 4'd4);
      cyc();
      chk($sformatf("t3.%0d.pulse", i), {done0, done1, busy}, 0);
    end
    req0 = 0; req1 = 0;
    cyc();

    // 4: -8 + -1 repeatedly, counter saturates at 255
    do_reset();
    a0 = 4'h8; b0 = 4'hF;
    for (int i = 0; i < 300; i++) begin
      req0 = 1;
      cyc();
      req0 = 0;
      cyc();
      chk($sformatf("t4.%0d.res", i), {overflow, result}, {1'b1, 4'd7});
      chk($sformatf("t4.%0d.cnt", i), ovf_cnt, (i < 254) ? i + 1 : 255);
      cyc();
    end
    req0 = 1;
    cyc();
    ovf_clr = 1; req0 = 0;
    cyc();
    ovf_clr = 0;
    chk("t4.clr_wins", ovf_cnt, 0);
    cyc();
    req0 = 1;
    cyc();
    req0 = 0;
    cyc();
    chk("t4.after_clr", ovf_cnt, 1);
    cyc();

    // 5: operand change during EXEC ignored; reset during EXEC aborts
    req0 = 1; a0 = 4'd2; b0 = 4'd2;
    cyc();
    req0 = 0; a0 = 4'd6;
    chk("t5.latched.rd1", add_rd1, 4'd2);
    cyc();
    chk("t5.latched.res", {overflow, result}, {1'b0, 4'd4});
    cyc();
    req0 = 1; a0 = 4'd1; b0 = 4'd1;
    cyc();
    chk("t5.abort.gnt", gnt0, 1);
    rst_n = 0; req0 = 0;
    #1;
    chk_all_zero("t5.abort");
    cyc();
    chk("t5.abort.nodone", {done0, done1}, 0);
    rst_n = 1;
    cyc();
    chk("t5.post.nodone", {done0, done1, busy}, 0);
    req0 = 1; a0 = 4'd3; b0 = 4'd3;
    req1 = 1; a1 = 4'd5; b1 = 4'd5;
    cyc();
    chk("t5.tie.gnt", {gnt0, gnt1}, 2'b10);
    req0 = 0; req1 = 0;
    cyc();
    chk("t5.tie.done", {done0, done1}, 2'b10);
    chk("t5.tie.res", {overflow, result}, {1'b0, 4'd6});
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
